hazard_forward_scoreboard: RTL and testbench

Parametrised successor to the pipeline's stall-only hazard detection unit. It keeps its own record of in-flight register writebacks across the post-decode stages, so it does not depend on the stage modules exporting their destination registers. From that record it produces data-hazard stalls, registered operand-forwarding selects, branch-flush control and memory-wait freeze. It sits beside the ID stage and drives IF/ID hold and flush and the EXE-stage operand muxes.

---
 rtl/hazard_forward_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_forward_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_scoreboard.sv
// Tracks in-flight writebacks across the post-ID stages and derives data-hazard stalls,
// registered EXE forwarding selects, branch flush and memory-wait freeze from that record.
module hazard_forward_scoreboard #(
  parameter int REG_AW = 4,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rn_addr,
  input  logic [REG_AW-1:0] rm_addr,
  input  logic              two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              branch_taken,
  input  logic              mem_wait,
  output logic              hazard,
  output logic              flush,
  output logic              freeze,
  output logic [SEL_W-1:0]  fwd_sel_rn,
  output logic [SEL_W-1:0]  fwd_sel_rm,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CMP = STAGES - 1;

  logic [STAGES-1:0] slot_vld_p;
  logic [STAGES-1:0] slot_wb_p;
  logic [STAGES-1:0] slot_ld_p;
  logic [REG_AW-1:0] slot_dest_p [STAGES];

  logic [CMP-1:0]    rn_hit;
  logic [CMP-1:0]    rm_hit;
  logic              raw_hazard;
  logic              issue;
  logic [SEL_W-1:0]  sel_rn_d;
  logic [SEL_W-1:0]  sel_rm_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Lowest matching slot wins; a load still in EXE cannot be forwarded, so it yields no select.
  function automatic logic [SEL_W-1:0] pick_sel(input logic [CMP-1:0] hit, input logic ld0);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int i = CMP - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i + 1);
    end
    if (hit[0] && ld0) sel = '0;
    return sel;
  endfunction

  // ID stage: compare sources against the EXE..pre-WB slots
  always_comb begin
    rn_hit = '0;
    rm_hit = '0;
    for (int i = 0; i < CMP; i++) begin
      rn_hit[i] = slot_vld_p[i] & slot_wb_p[i] & (slot_dest_p[i] == rn_addr);
      rm_hit[i] = two_src & slot_vld_p[i] & slot_wb_p[i] & (slot_dest_p[i] == rm_addr);
    end
  end

  always_comb begin
    raw_hazard = 1'b0;
    if (FWD_EN != 0) raw_hazard = (rn_hit[0] | rm_hit[0]) & slot_ld_p[0];
    else             raw_hazard = |(rn_hit | rm_hit);
  end

  assign hazard   = id_valid & raw_hazard & ~branch_taken & ~mem_wait;
  assign flush    = branch_taken & ~mem_wait;
  assign freeze   = mem_wait;
  assign issue    = id_valid & ~hazard & ~branch_taken;
  assign sel_rn_d = pick_sel(rn_hit, slot_ld_p[0]);
  assign sel_rm_d = pick_sel(rm_hit, slot_ld_p[0]);

  // Slot advance into EXE/MEM/.../WB, selects and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p <= '0;
      slot_wb_p  <= '0;
      slot_ld_p  <= '0;
      fwd_sel_rn <= '0;
      fwd_sel_rm <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (!mem_wait) begin
      slot_vld_p[0] <= issue;
      slot_wb_p[0]  <= issue & id_wb_en;
      slot_ld_p[0]  <= issue & id_mem_r_en;
      for (int i = 1; i < STAGES; i++) begin
        slot_vld_p[i] <= slot_vld_p[i-1];
        slot_wb_p[i]  <= slot_wb_p[i-1];
        slot_ld_p[i]  <= slot_ld_p[i-1];
      end
      fwd_sel_rn <= (FWD_EN != 0 && issue) ? sel_rn_d : '0;
      fwd_sel_rm <= (FWD_EN != 0 && issue) ? sel_rm_d : '0;
      if (hazard) stall_cnt <= sat_inc(stall_cnt);
      if (flush)  flush_cnt <= sat_inc(flush_cnt);
    end
  end

  // Destination tags are qualified by vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (!mem_wait) begin
      slot_dest_p[0] <= issue ? id_dest : '0;
      for (int i = 1; i < STAGES; i++) slot_dest_p[i] <= slot_dest_p[i-1];
    end
  end

  // WB slot and deeper load flags are carried for completeness but never compared.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{slot_vld_p[STAGES-1], slot_wb_p[STAGES-1],
                              slot_ld_p[STAGES-1:1], slot_dest_p[STAGES-1]};

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed bench for hazard_forward_scoreboard: forwarding, stall-only and narrow-counter builds.
module tb_hazard_forward_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] rn_addr;
  logic [3:0] rm_addr;
  logic       two_src;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       branch_taken;
  logic       mem_wait;

  logic        a_hazard, a_flush, a_freeze;
  logic [1:0]  a_sel_rn, a_sel_rm;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_hazard, b_flush, b_freeze;
  logic [1:0]  b_sel_rn, b_sel_rm;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic        c_hazard, c_flush, c_freeze;
  logic [1:0]  c_sel_rn, c_sel_rm;
  logic [1:0]  c_stall_cnt, c_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_forward_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn_addr(rn_addr), .rm_addr(rm_addr),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(a_hazard), .flush(a_flush),
    .freeze(a_freeze), .fwd_sel_rn(a_sel_rn), .fwd_sel_rm(a_sel_rm),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_forward_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(0), .CNT_W(16)) u_stall (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn_addr(rn_addr), .rm_addr(rm_addr),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(b_hazard), .flush(b_flush),
    .freeze(b_freeze), .fwd_sel_rn(b_sel_rn), .fwd_sel_rm(b_sel_rm),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  hazard_forward_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn_addr(rn_addr), .rm_addr(rm_addr),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .mem_wait(mem_wait), .hazard(c_hazard), .flush(c_flush),
    .freeze(c_freeze), .fwd_sel_rn(c_sel_rn), .fwd_sel_rm(c_sel_rm),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                     input logic two, input logic [3:0] dest, input logic wb,
                     input logic ld, input logic br, input logic mw);
    id_valid     = v;
    rn_addr      = rn;
    rm_addr      = rm;
    two_src      = two;
    id_dest      = dest;
    id_wb_en     = wb;
    id_mem_r_en  = ld;
    branch_taken = br;
    mem_wait     = mw;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    mid();
    chk("rst_hazard",        a_hazard,    0);
    chk("rst_flush_follows", a_flush,     1);
    chk("rst_sel_rn",        a_sel_rn,    0);
    chk("rst_sel_rm",        a_sel_rm,    0);
    chk("rst_stall_cnt",     a_stall_cnt, 0);
    chk("rst_flush_cnt",     a_flush_cnt, 0);
    chk("rst_b_stall_cnt",   b_stall_cnt, 0);
    chk("rst_b_flush_cnt",   b_flush_cnt, 0);
    chk("rst_c_stall_cnt",   c_stall_cnt, 0);
    chk("rst_c_flush_cnt",   c_flush_cnt, 0);
    chk("rst_b_sel",         {b_sel_rn, b_sel_rm, c_sel_rn, c_sel_rm}, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_freeze_follows", {a_freeze, b_freeze, c_freeze}, 3'b111);
    chk("rst_flush_gone",     {a_flush, b_flush, c_flush, b_hazard, c_hazard}, 0);
    do_reset();

    // ADD r1 then SUB rn=r1 forwards from MEM
    drv(1, 2, 0, 0, 1, 1, 0, 0, 0); mid(); chk("t1_add_haz", a_hazard, 0); cyc();
    drv(1, 1, 0, 0, 6, 1, 0, 0, 0); mid(); chk("t1_sub_haz", a_hazard, 0); cyc();
    chk("t1_sel_rn", a_sel_rn, 1);
    chk("t1_sel_rm", a_sel_rm, 0);

    // ADD r2, NOP, ORR rm=r2
    do_reset();
    drv(1, 0, 0, 0, 2, 1, 0, 0, 0); cyc();
    idle(); cyc();
    drv(1, 7, 2, 1, 8, 1, 0, 0, 0); mid(); chk("t2_orr_haz", a_hazard, 0); cyc();
    chk("t2_sel_rm", a_sel_rm, 2);
    chk("t2_sel_rn", a_sel_rn, 0);
    do_reset();
    drv(1, 0, 0, 0, 2, 1, 0, 0, 0); cyc();
    idle(); cyc();
    drv(1, 7, 2, 0, 8, 1, 0, 0, 0); cyc();
    chk("t2_one_src_sel_rm", a_sel_rm, 0);

    // load whose wb_en=0 neither stalls nor forwards
    do_reset();
    drv(1, 0, 0, 0, 3, 0, 1, 0, 0); cyc();
    drv(1, 3, 3, 1, 9, 1, 0, 0, 0); mid(); chk("t_nowb_haz", a_hazard, 0); cyc();
    chk("t_nowb_sel", {a_sel_rn, a_sel_rm}, 0);
    chk("t_nowb_stall_cnt", a_stall_cnt, 0);

    // LDR r3 then ADD rn=r3: one stall, then forward from WB
    do_reset();
    drv(1, 0, 0, 0, 3, 1, 1, 0, 0); cyc();
    drv(1, 3, 0, 0, 9, 1, 0, 0, 0); mid(); chk("t3_haz1", a_hazard, 1); cyc();
    chk("t3_stall_cnt", a_stall_cnt, 1);
    chk("t3_bubble_sel", a_sel_rn, 0);
    mid(); chk("t3_haz2", a_hazard, 0); cyc();
    chk("t3_sel_rn", a_sel_rn, 2);
    chk("t3_stall_cnt_hold", a_stall_cnt, 1);

    // stall-only: ADD r4 then SUB rn=r4 stalls two cycles, never forwards
    do_reset();
    drv(1, 0, 0, 0, 4, 1, 0, 0, 0); cyc();
    drv(1, 4, 0, 0, 10, 1, 0, 0, 0);
    mid(); chk("t4_haz_c1", b_hazard, 1); chk("t4_fwd_nohaz", a_hazard, 0); cyc();
    chk("t4_sel_c1", b_sel_rn, 0);
    mid(); chk("t4_haz_c2", b_hazard, 1); cyc();
    chk("t4_sel_c2", b_sel_rn, 0);
    mid(); chk("t4_haz_c3", b_hazard, 0); cyc();
    chk("t4_sel_c3", b_sel_rn, 0);
    chk("t4_stall_cnt", b_stall_cnt, 2);

    // load-use together with taken branch: flush wins, bubble inserted
    do_reset();
    drv(1, 0, 0, 0, 3, 1, 1, 0, 0); cyc();
    drv(1, 3, 0, 0, 9, 1, 0, 1, 0);
    mid(); chk("t5_haz", a_hazard, 0); chk("t5_flush", a_flush, 1); cyc();
    chk("t5_flush_cnt", a_flush_cnt, 1);
    chk("t5_stall_cnt", a_stall_cnt, 0);
    drv(1, 9, 0, 0, 11, 1, 0, 0, 0); mid(); chk("t5_next_haz", a_hazard, 0); cyc();
    chk("t5_bubble_no_fwd", a_sel_rn, 0);

    // mem_wait during a load-use stall freezes everything
    do_reset();
    drv(1, 0, 0, 0, 3, 1, 1, 0, 0); cyc();
    drv(1, 3, 0, 0, 9, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t6_freeze", a_freeze, 1);
      chk("t6_haz_masked", a_hazard, 0);
      cyc();
      chk("t6_stall_cnt_hold", a_stall_cnt, 0);
    end
    drv(1, 3, 0, 0, 9, 1, 0, 0, 0);
    mid(); chk("t6_haz_after", a_hazard, 1); chk("t6_unfreeze", a_freeze, 0); cyc();
    chk("t6_stall_cnt", a_stall_cnt, 1);
    mid(); chk("t6_haz_done", a_hazard, 0); cyc();
    chk("t6_sel_rn", a_sel_rn, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    mid(); chk("t6_br_mw_flush", a_flush, 0); chk("t6_br_mw_freeze", a_freeze, 1); cyc();
    chk("t6_br_mw_flush_cnt", a_flush_cnt, 0);

    // five stall cycles on the narrow counter saturate at 3
    do_reset();
    drv(1, 0, 0, 0, 4, 1, 0, 0, 0); cyc();
    drv(1, 4, 0, 0, 10, 1, 0, 0, 0); cyc(); cyc(); cyc();
    chk("t7_c_cnt_2", c_stall_cnt, 2);
    drv(1, 0, 0, 0, 4, 1, 0, 0, 0); cyc();
    drv(1, 4, 0, 0, 10, 1, 0, 0, 0); cyc(); cyc(); cyc();
    chk("t7_c_cnt_4", c_stall_cnt, 3);
    drv(1, 0, 0, 0, 5, 1, 0, 0, 0); cyc();
    idle(); cyc();
    drv(1, 5, 0, 0, 12, 1, 0, 0, 0); mid(); chk("t7_haz_mem_slot", c_hazard, 1); cyc();
    mid(); chk("t7_haz_clear", c_hazard, 0); cyc();
    idle(); cyc();
    chk("t7_c_cnt_sat", c_stall_cnt, 3);
    chk("t7_b_cnt_wide", b_stall_cnt, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
